led_pattern_sequencer: RTL and testbench

Sequences the LED blinker through a stored list of blink-rate steps, each held for a programmed dwell time, so the blinker runs a visible pattern without a person changing switches. Sits directly upstream of the blinker: its outputs drive the blinker's enable and two rate-select inputs. A debounced push-button starts and stops the sequence; a 2-bit selector picks one of four patterns at start time.

---
 rtl/led_seq_pkg.sv | 42 ++++
 rtl/button_debouncer.sv | 41 ++++
 rtl/led_pattern_sequencer.sv | 105 ++++++++++
 tb/tb_led_pattern_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types, rate codes and the blink pattern table for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [1:0] RATE_100 = 2'b00;
    localparam logic [1:0] RATE_50  = 2'b01;
    localparam logic [1:0] RATE_10  = 2'b10;
    localparam logic [1:0] RATE_1   = 2'b11;

    // Five dwell bits so the 3 s step (30 units) fits; dwell 0 marks the end of a pattern.
    localparam int DWELL_W = 5;

    typedef struct packed {
        logic [1:0]         rate;
        logic [DWELL_W-1:0] dwell;
    } step_t;

    typedef step_t [0:7] pattern_t;

    localparam step_t END_MARK = '0;

    localparam pattern_t [0:3] PATTERN_TABLE = '{
        '{step_t'{RATE_100, 5'd10}, step_t'{RATE_50, 5'd10}, step_t'{RATE_10, 5'd10},
          step_t'{RATE_1, 5'd30}, END_MARK, END_MARK, END_MARK, END_MARK},
        '{step_t'{RATE_1, 5'd5}, END_MARK, END_MARK, END_MARK,
          END_MARK, END_MARK, END_MARK, END_MARK},
        '{step_t'{RATE_10, 5'd5}, step_t'{RATE_100, 5'd5}, END_MARK, END_MARK,
          END_MARK, END_MARK, END_MARK, END_MARK},
        '{END_MARK, END_MARK, END_MARK, END_MARK,
          END_MARK, END_MARK, END_MARK, END_MARK}
    };

    function automatic step_t pattern_entry(input logic [1:0] pat, input logic [2:0] step);
        return PATTERN_TABLE[pat][step];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, stability counter and a 1-cycle pulse on each accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          flip;

    // The counter tracks how long the synchronized input has disagreed with the accepted level.
    assign differ  = sync_q[1] != level_q;
    assign flip    = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    assign cnt_d   = (flip || !differ) ? '0 : cnt_q + 1'b1;
    assign press_o = press_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_q ^ flip;
            press_q <= flip && !level_q;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps the blinker through a stored pattern of rate/dwell entries,
// started and stopped by a debounced push-button.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ          = 25_000_000,
    parameter int TICK_CYCLES     = CLK_HZ / 10,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_start_stop,
    input  logic [1:0] i_pattern_sel,
    output logic       o_enable,
    output logic       o_switch_1,
    output logic       o_switch_2,
    output logic       o_running,
    output logic [2:0] o_step
);

    localparam int PW = $clog2(TICK_CYCLES);

    logic               press;
    step_t              entry;
    logic               tick_wrap;
    state_e             state_q;
    logic [1:0]         sel_q;
    logic [2:0]         step_q;
    logic [PW-1:0]      presc_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               en_q;
    logic [1:0]         rate_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk_i  (i_clock),
        .rst_ni (i_reset_n),
        .btn_i  (i_start_stop),
        .press_o(press)
    );

    assign entry     = pattern_entry(sel_q, step_q);
    assign tick_wrap = presc_q == PW'(TICK_CYCLES - 1);

    // A press while active always wins over step advance and loop-back.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            step_q  <= '0;
            presc_q <= '0;
            dwell_q <= '0;
            en_q    <= 1'b0;
            rate_q  <= RATE_100;
        end else if (state_q != S_IDLE && press) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            presc_q <= '0;
            dwell_q <= '0;
            en_q    <= 1'b0;
            rate_q  <= RATE_100;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press) begin
                        state_q <= S_LOAD;
                        sel_q   <= i_pattern_sel;
                        step_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (entry.dwell == '0) begin
                        if (step_q == '0) state_q <= S_IDLE;
                        step_q <= '0;
                    end else begin
                        state_q <= S_RUN;
                        rate_q  <= entry.rate;
                        en_q    <= 1'b1;
                        dwell_q <= entry.dwell;
                        presc_q <= '0;
                    end
                end
                S_RUN: begin
                    presc_q <= tick_wrap ? '0 : presc_q + 1'b1;
                    if (tick_wrap) begin
                        dwell_q <= dwell_q - 1'b1;
                        if (dwell_q == DWELL_W'(1)) begin
                            state_q <= S_LOAD;
                            step_q  <= step_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_enable   = en_q;
    assign o_switch_1 = rate_q[1];
    assign o_switch_2 = rate_q[0];
    assign o_running  = state_q != S_IDLE;
    assign o_step     = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed stimulus against a cycle-level behavioural model of the sequencer.
module tb_led_pattern_sequencer;

    localparam int TICK = 10;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       en, sw1, sw2, running;
    logic [2:0] step;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    led_pattern_sequencer #(
        .CLK_HZ         (100),
        .TICK_CYCLES    (TICK),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_start_stop (btn),
        .i_pattern_sel(sel),
        .o_enable     (en),
        .o_switch_1   (sw1),
        .o_switch_2   (sw2),
        .o_running    (running),
        .o_step       (step)
    );

    always #5 clk = ~clk;

    // Pattern contents written straight from the table description.
    function automatic int dwell_of(input int p, input int s);
        case (p)
            0: return s < 3 ? 10 : (s == 3 ? 30 : 0);
            1: return s == 0 ? 5 : 0;
            2: return s < 2 ? 5 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int rate_of(input int p, input int s);
        case (p)
            0: return s;
            1: return 3;
            2: return s == 0 ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    // Model: mode 0 idle, 1 load, 2 run; a step is tracked as remaining RUN cycles.
    int mode = 0, pat = 0, mstep = 0, left = 0, mrate = 0, run_len = 0, presses = 0;
    bit men = 0, s1 = 0, s2 = 0, lvl = 0, mpress = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mode = 0; pat = 0; mstep = 0; left = 0; mrate = 0; men = 0;
            s1 = 0; s2 = 0; lvl = 0; mpress = 0; run_len = 0;
        end else begin
            bit np;
            if (mode == 0) begin
                if (mpress) begin mode = 1; pat = int'(sel); mstep = 0; end
            end else if (mpress) begin
                mode = 0; men = 0; mrate = 0; mstep = 0;
            end else if (mode == 1) begin
                if (dwell_of(pat, mstep) == 0) begin
                    if (mstep == 0) mode = 0;
                    mstep = 0;
                end else begin
                    mode = 2; men = 1; mrate = rate_of(pat, mstep);
                    left = dwell_of(pat, mstep) * TICK;
                end
            end else begin
                left--;
                if (left == 0) begin mode = 1; mstep = (mstep + 1) % 8; end
            end
            np = 0;
            if (s2 != lvl) begin
                run_len++;
                if (run_len == DEB) begin lvl = s2; run_len = 0; np = lvl; end
            end else run_len = 0;
            mpress = np;
            if (np) presses++;
            s2 = s1;
            s1 = btn;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [6:0] act, exp;
            act = {en, sw1, sw2, running, step};
            exp = {men, 2'(mrate), mode != 0, 3'(mstep)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got en/sw/run/step=%b expected %b", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press_btn();
        @(negedge clk); btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, r, e, p0;
        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({en, sw1, sw2, running, step}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_outputs", int'({en, sw1, sw2, running, step}), 0);

        // First step of P0 and press-to-enable latency.
        sel = 2'd0;
        btn = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!en && n < 20);
        chk("press_to_enable", n, 8);
        chk("first_rate", int'({sw1, sw2}), 0);
        btn = 1'b0;
        n = 0;
        while (step == 3'd0 && n < 200) begin @(negedge clk); n++; end
        chk("step0_len", n, 100);
        @(negedge clk);
        chk("step1_rate", int'({sw1, sw2}), 1);

        // Long step and loop-back.
        n = 0;
        while (!(step == 3'd3 && {sw1, sw2} == 2'b11) && n < 600) begin @(negedge clk); n++; end
        n = 0;
        while (step == 3'd3 && n < 400) begin @(negedge clk); n++; end
        chk("step3_len", n, 300);
        chk("end_marker_step", int'(step), 4);
        @(negedge clk);
        chk("loopback_step", int'(step), 0);
        chk("loopback_hold_rate", int'({sw1, sw2}), 3);
        @(negedge clk);
        chk("restart_rate", int'({en, sw1, sw2}), 4);
        press_btn();
        chk("stop_p0", int'(running), 0);

        // Empty pattern.
        sel = 2'd3;
        btn = 1'b1;
        r = 0; e = 0;
        repeat (20) begin @(negedge clk); r += int'(running); e += int'(en); end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        chk("empty_running_cycles", r, 1);
        chk("empty_enable_cycles", e, 0);

        // Stop in the middle of P2 step 1, then restart.
        sel = 2'd2;
        press_btn();
        n = 0;
        while (step != 3'd1 && n < 100) begin @(negedge clk); n++; end
        chk("p2_reach_step1", int'(step), 1);
        repeat (13) @(negedge clk);
        btn = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (running && n < 20);
        chk("stop_latency", n, 7);
        chk("stop_outputs", int'({en, sw1, sw2, step}), 0);
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        press_btn();
        chk("restart_state", int'({en, sw1, sw2, running, step}), 7'b1101000);
        press_btn();
        chk("stop_p2", int'(running), 0);

        // Debounce: short bounces are ignored, a held press counts once, release counts never.
        sel = 2'd1;
        p0 = presses;
        for (int w = 1; w <= 3; w++) begin
            btn = 1'b1;
            repeat (w) @(negedge clk);
            btn = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("bounce_no_run", int'(running), 0);
        chk("bounce_no_press", presses - p0, 0);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_press_run", int'({en, running}), 3);
        chk("held_press_count", presses - p0, 1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_now", int'({en, sw1, sw2, running, step}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("after_reset_idle", int'({en, running}), 0);
        chk("press_total", presses, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
